dmem_arbiter: RTL and testbench

//  Shares the single data-memory port between the core MEM stage (EX/MEM register) and a

---
 rtl/dmem_arbiter.sv | 93 +++++++++
 tb/tb_dmem_arbiter.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// Data-memory port arbiter: EX/MEM core access vs. debug/loader port.
// Core wins; a debug request denied MAX_WAIT cycles steals one slot.
module dmem_arbiter #(
  parameter int DM_ADDRESS = 9,
  parameter int DATA_W     = 32,
  parameter int MAX_WAIT   = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  core_rd,
  input  logic                  core_wr,
  input  logic [DM_ADDRESS-1:0] core_addr,
  input  logic [DATA_W-1:0]     core_wdata,
  input  logic [2:0]            core_funct3,
  output logic [DATA_W-1:0]     core_rdata,
  output logic                  core_stall,
  input  logic                  dbg_req,
  input  logic                  dbg_we,
  input  logic [DM_ADDRESS-1:0] dbg_addr,
  input  logic [DATA_W-1:0]     dbg_wdata,
  output logic                  dbg_gnt,
  output logic                  dbg_rvalid,
  output logic [DATA_W-1:0]     dbg_rdata,
  output logic                  mem_rd,
  output logic                  mem_wr,
  output logic [DM_ADDRESS-1:0] mem_addr,
  output logic [DATA_W-1:0]     mem_wdata,
  output logic [2:0]            mem_funct3,
  input  logic [DATA_W-1:0]     mem_rdata
);

  localparam int CW = $clog2(MAX_WAIT + 1);
  localparam logic [CW-1:0] WMAX = CW'(MAX_WAIT);

  logic [CW-1:0]     wait_cnt_q, wait_cnt_d;
  logic              rvalid_q, rvalid_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              core_req;
  logic              dbg_sel;

  assign core_req = core_rd | core_wr;
  assign dbg_sel  = reset & dbg_req &
                    (~core_req | (wait_cnt_q == WMAX));

  assign core_rdata = mem_rdata;
  assign dbg_gnt    = dbg_sel;
  assign core_stall = dbg_sel & core_req;
  assign dbg_rvalid = rvalid_q;
  assign dbg_rdata  = rdata_q;

  always_comb begin
    mem_rd     = 1'b0;
    mem_wr     = 1'b0;
    mem_addr   = core_addr;
    mem_wdata  = core_wdata;
    mem_funct3 = core_funct3;
    if (dbg_sel) begin
      mem_rd     = ~dbg_we;
      mem_wr     = dbg_we;
      mem_addr   = dbg_addr;
      mem_wdata  = dbg_wdata;
      mem_funct3 = 3'b010;
    end else if (reset) begin
      // write wins so the memory never sees rd and wr together
      mem_wr = core_wr;
      mem_rd = core_rd & ~core_wr;
    end
  end

  always_comb begin
    wait_cnt_d = wait_cnt_q;
    if (!dbg_req || dbg_sel) begin
      wait_cnt_d = '0;
    end else if (core_req && wait_cnt_q != WMAX) begin
      wait_cnt_d = wait_cnt_q + CW'(1);
    end
    rvalid_d = dbg_sel & ~dbg_we;
    rdata_d  = rvalid_d ? mem_rdata : rdata_q;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wait_cnt_q <= '0;
      rvalid_q   <= 1'b0;
      rdata_q    <= '0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
      rvalid_q   <= rvalid_d;
      rdata_q    <= rdata_d;
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: vector table, directed corner
// sequences and a randomized run against a request-level model.
module tb_dmem_arbiter;

  localparam int MW = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        core_rd, core_wr;
  logic [8:0]  core_addr;
  logic [31:0] core_wdata;
  logic [2:0]  core_funct3;
  logic [31:0] core_rdata;
  logic        core_stall;
  logic        dbg_req, dbg_we;
  logic [8:0]  dbg_addr;
  logic [31:0] dbg_wdata;
  logic        dbg_gnt, dbg_rvalid;
  logic [31:0] dbg_rdata;
  logic        mem_rd, mem_wr;
  logic [8:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic [2:0]  mem_funct3;
  logic [31:0] mem_rdata;

  logic [31:0] mem [128];
  logic [31:0] ref_mem [128];

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  dmem_arbiter #(.DM_ADDRESS(9), .DATA_W(32), .MAX_WAIT(MW)) dut (
    .clk(clk), .reset(reset),
    .core_rd(core_rd), .core_wr(core_wr),
    .core_addr(core_addr), .core_wdata(core_wdata),
    .core_funct3(core_funct3), .core_rdata(core_rdata),
    .core_stall(core_stall),
    .dbg_req(dbg_req), .dbg_we(dbg_we),
    .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_gnt(dbg_gnt), .dbg_rvalid(dbg_rvalid),
    .dbg_rdata(dbg_rdata),
    .mem_rd(mem_rd), .mem_wr(mem_wr),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_funct3(mem_funct3), .mem_rdata(mem_rdata)
  );

  assign mem_rdata = mem[mem_addr[8:2]];
  always @(posedge clk) if (mem_wr) mem[mem_addr[8:2]] <= mem_wdata;

  task automatic chk(string nm, logic [31:0] act,
                     logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h want %h at %0t",
               nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    core_rd = 0; core_wr = 0; dbg_req = 0; dbg_we = 0;
  endtask

  typedef struct {
    logic crd, cwr, dreq, dwe;
    logic egnt, estall, emrd, emwr;
  } vec_t;

  vec_t tbl[7];

  // request-level model state for the random run
  int          denied;
  logic        exp_rv;
  logic [31:0] exp_rd;
  logic        held, clr_req;
  logic        e_gnt, e_stall, e_rd, e_wr, creq;
  logic [8:0]  e_addr;
  int          ngnt;

  initial begin
    for (int i = 0; i < 128; i++) mem[i] = 32'h1000_0000 + i;
    idle();
    reset = 0;
    core_addr = '0; core_wdata = '0; core_funct3 = 3'b010;
    dbg_addr = '0; dbg_wdata = '0;

    tbl[0] = '{0,0,0,0, 0,0,0,0};
    tbl[1] = '{1,0,0,0, 0,0,1,0};
    tbl[2] = '{0,1,0,0, 0,0,0,1};
    tbl[3] = '{0,0,1,0, 1,0,1,0};
    tbl[4] = '{0,0,1,1, 1,0,0,1};
    tbl[5] = '{1,0,1,1, 0,0,1,0};
    tbl[6] = '{0,1,1,0, 0,0,0,1};

    // 1: reset gates everything even with requests present
    core_rd = 1; dbg_req = 1;
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("rst_mem_rd", mem_rd, 0);
      chk("rst_mem_wr", mem_wr, 0);
      chk("rst_gnt", dbg_gnt, 0);
      chk("rst_stall", core_stall, 0);
      chk("rst_rvalid", dbg_rvalid, 0);
      chk("rst_rdata", dbg_rdata, 0);
    end
    tick();
    reset = 1; dbg_req = 0; core_rd = 1; core_addr = 9'h010;
    #1;
    chk("lw_mem_rd", mem_rd, 1);
    chk("lw_addr", mem_addr, 9'h010);
    chk("lw_stall", core_stall, 0);
    chk("lw_rdata", core_rdata, 32'h1000_0004);

    // table: one vector per cycle from a cleared counter
    foreach (tbl[k]) begin
      tick();
      core_rd = tbl[k].crd; core_wr = tbl[k].cwr;
      dbg_req = tbl[k].dreq; dbg_we = tbl[k].dwe;
      core_addr = 9'h1F8; dbg_addr = 9'h1FC;
      #1;
      chk($sformatf("tbl%0d_gnt", k), dbg_gnt, tbl[k].egnt);
      chk($sformatf("tbl%0d_stall", k), core_stall,
          tbl[k].estall);
      chk($sformatf("tbl%0d_rd", k), mem_rd, tbl[k].emrd);
      chk($sformatf("tbl%0d_wr", k), mem_wr, tbl[k].emwr);
      tick();
      idle();
    end

    // 2: debug write then read back, core idle
    tick();
    dbg_req = 1; dbg_we = 1; dbg_addr = 9'h040;
    dbg_wdata = 32'hDEADBEEF;
    #1;
    chk("dw_gnt", dbg_gnt, 1);
    chk("dw_wr", mem_wr, 1);
    chk("dw_addr", mem_addr, 9'h040);
    chk("dw_f3", mem_funct3, 3'b010);
    tick();
    idle();
    tick();
    dbg_req = 1; dbg_we = 0;
    #1;
    chk("dr_gnt", dbg_gnt, 1);
    chk("dr_rd", mem_rd, 1);
    chk("dr_rv_early", dbg_rvalid, 0);
    tick();
    idle();
    chk("dr_rvalid", dbg_rvalid, 1);
    chk("dr_rdata", dbg_rdata, 32'hDEADBEEF);
    tick();
    chk("dr_rv_pulse", dbg_rvalid, 0);
    chk("dr_hold", dbg_rdata, 32'hDEADBEEF);

    // 3: core store held, debug write forced on 5th cycle
    core_wr = 1; core_addr = 9'h080; core_wdata = 32'hCAFEF00D;
    dbg_req = 1; dbg_we = 1; dbg_addr = 9'h044;
    dbg_wdata = 32'h12345678;
    for (int i = 0; i <= MW; i++) begin
      #1;
      chk($sformatf("st_gnt%0d", i), dbg_gnt, i == MW);
      chk($sformatf("st_stall%0d", i), core_stall, i == MW);
      chk($sformatf("st_addr%0d", i), mem_addr,
          i == MW ? 9'h044 : 9'h080);
      tick();
    end
    dbg_req = 0;
    #1;
    chk("st_after_stall", core_stall, 0);
    chk("st_after_wr", mem_wr, 1);
    tick();
    idle();
    chk("st_mem_core", mem[9'h080 >> 2], 32'hCAFEF00D);
    chk("st_mem_dbg", mem[9'h044 >> 2], 32'h12345678);

    // 4: continuous traffic, debug gets every 5th cycle
    core_rd = 1; core_addr = 9'h010;
    dbg_req = 1; dbg_we = 0; dbg_addr = 9'h040;
    ngnt = 0;
    for (int i = 0; i < 25; i++) begin
      #1;
      chk($sformatf("cont_gnt%0d", i), dbg_gnt,
          (i % 5) == 4);
      if (!core_stall) ngnt++;
      tick();
    end
    chk("cont_progress", ngnt, 20);
    idle();
    tick();

    // 5: reset right after a read grant kills the rvalid
    dbg_req = 1; dbg_we = 0; dbg_addr = 9'h080;
    #1;
    chk("rr_gnt", dbg_gnt, 1);
    reset = 0;
    tick();
    reset = 1; idle();
    #1;
    chk("rr_rvalid", dbg_rvalid, 0);
    chk("rr_rdata", dbg_rdata, 0);
    tick();
    chk("rr_rvalid2", dbg_rvalid, 0);

    // 6: cancel after 2 denials, re-request waits the full count
    core_rd = 1; dbg_req = 1;
    for (int i = 0; i < 2; i++) begin
      #1;
      chk($sformatf("cx_deny%0d", i), dbg_gnt, 0);
      tick();
    end
    dbg_req = 0;
    #1;
    chk("cx_drop_rd", mem_rd, 1);
    tick();
    dbg_req = 1;
    for (int i = 0; i <= MW; i++) begin
      #1;
      chk($sformatf("cx_gnt%0d", i), dbg_gnt, i == MW);
      tick();
    end
    idle();
    tick();

    // randomized run against a request-level model
    for (int i = 0; i < 128; i++) ref_mem[i] = mem[i];
    denied = 0; exp_rv = 0; exp_rd = 0;
    held = 0; clr_req = 0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      if (!held) begin
        case ($urandom_range(0, 3))
          0: begin core_rd = 0; core_wr = 0; end
          1, 2: begin core_rd = 1; core_wr = 0; end
          default: begin core_rd = 0; core_wr = 1; end
        endcase
        core_addr = 9'($urandom_range(0, 127) << 2);
        core_wdata = $urandom;
      end
      if (clr_req) dbg_req = 0;
      if (!dbg_req) begin
        if ($urandom_range(0, 2) == 0) begin
          dbg_req = 1; dbg_we = 1'($urandom_range(0, 1));
          dbg_addr = 9'($urandom_range(0, 127) << 2);
          dbg_wdata = $urandom;
        end
      end else if ($urandom_range(0, 9) == 0) begin
        dbg_req = 0;
      end
      #1;
      creq = core_rd | core_wr;
      e_gnt = dbg_req && (!creq || denied >= MW);
      e_stall = e_gnt && creq;
      e_rd = e_gnt ? !dbg_we : core_rd;
      e_wr = e_gnt ? dbg_we : core_wr;
      e_addr = e_gnt ? dbg_addr : core_addr;
      chk("rnd_gnt", dbg_gnt, e_gnt);
      chk("rnd_stall", core_stall, e_stall);
      chk("rnd_rd", mem_rd, e_rd);
      chk("rnd_wr", mem_wr, e_wr);
      if (e_rd || e_wr) chk("rnd_addr", mem_addr, e_addr);
      chk("rnd_rvalid", dbg_rvalid, exp_rv);
      if (exp_rv) chk("rnd_rdata", dbg_rdata, exp_rd);
      if (!e_gnt && core_rd)
        chk("rnd_core_rdata", core_rdata,
            ref_mem[core_addr[8:2]]);
      exp_rv = 0;
      if (e_gnt) begin
        denied = 0;
        if (dbg_we) ref_mem[dbg_addr[8:2]] = dbg_wdata;
        else begin
          exp_rv = 1;
          exp_rd = ref_mem[dbg_addr[8:2]];
        end
      end else begin
        if (!dbg_req) denied = 0;
        else if (creq && denied < MW) denied++;
        if (core_wr) ref_mem[core_addr[8:2]] = core_wdata;
      end
      held = e_stall;
      clr_req = e_gnt;
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
